spi_slave_regif: RTL and testbench
==================================

SPI_SLAVE_REGIF -- requirements
Module: spi_slave_regif

Interface
REQ-001 The block SHALL have parameter CMD_WIDTH, default 5, giving the command field width: R/W bit plus address.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, giving the register address width (16 registers).
REQ-003 The block SHALL have parameter DATA_WIDTH, default 11, giving the register data width.
REQ-004 The block SHALL have port sys_clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 The block SHALL have port sys_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port spi_cs_n, input, 1 bit: chip select, active-low, asynchronous to sys_clk.
REQ-007 The block SHALL have port spi_sclk, input, 1 bit: serial clock, mode 0, idle low.
REQ-008 The block SHALL have port spi_mosi, input, 1 bit: serial data in, MSB first.
REQ-009 The block SHALL have port spi_miso, output, 1 bit: serial data out, MSB first.
REQ-010 The block SHALL have port spi_miso_oe, output, 1 bit: MISO output enable, high only while selected.
REQ-011 The block SHALL have port reg_wr, output, 1 bit: one-cycle pulse when a register write commits.
REQ-012 The block SHALL have port reg_waddr, output, ADDR_WIDTH bits: address of the committed write.
REQ-013 The block SHALL have port reg_wdata, output, DATA_WIDTH bits: data of the committed write.
REQ-014 The block SHALL have port cfg_raddr, input, ADDR_WIDTH bits: core-side read address.
REQ-015 The block SHALL have port cfg_rdata, output, DATA_WIDTH bits: combinational read of register cfg_raddr.
REQ-016 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on an aborted (short) frame.

Function
REQ-017 spi_cs_n, spi_sclk and spi_mosi SHALL each pass a 2-FF synchronizer; SCLK rise and fall and CS fall and rise are detected from the synchronized values.
REQ-018 sys_clk period SHALL be at most one third of min(tCLKL, tCLKH); with 40 ns phases, 100 MHz is the reference rate.
REQ-019 A frame SHALL be CMD_WIDTH+DATA_WIDTH = 16 bits: bit15 R/W (0 = write, 1 = read), bits14:11 address, bits10:0 data.
REQ-020 MOSI SHALL be sampled on each synchronized SCLK rise; a 5-bit bit counter increments per rise and saturates at 16.
REQ-021 The FSM SHALL have states IDLE, CMD, DATA and DONE: IDLE->CMD on CS fall; CMD->DATA after the 5th rise; DATA->DONE after the 16th rise; any state->IDLE on CS rise.
REQ-022 On a read, the register at the address SHALL be loaded into the TX shift register in the cycle after the 5th rise.
REQ-023 On a read, MISO SHALL present data bit10 after the 5th SCLK fall and shift one bit per subsequent fall.
REQ-024 MISO SHALL be 0 during CMD, during write frames, and after the 16th bit.
REQ-025 spi_miso_oe SHALL equal the synchronized inverse of spi_cs_n.
REQ-026 On a write, the register SHALL update 1 sys_clk after the 16th rise is detected, with reg_wr pulsed for exactly one cycle and reg_waddr/reg_wdata valid in that cycle.
REQ-027 SCLK rises beyond 16 SHALL be ignored until CS rises: no second write and no shifting, with MISO held at 0.
REQ-028 A CS rise with 1 to 15 bits received SHALL discard the frame, perform no write and pulse frame_err; a CS rise with 0 bits SHALL NOT flag an error.
REQ-029 A CS fall SHALL clear the bit counter and shift registers, so back-to-back frames are independent.
REQ-030 A core read of an address in the same cycle as a write commit to it SHALL return the old value; the new value appears the next cycle.

Reset
REQ-031 While sys_rst is high, all 16 registers, the FSM (IDLE), counter, shift registers and synchronizers SHALL clear, with spi_miso=0, spi_miso_oe=0, reg_wr=0, reg_waddr=0, reg_wdata=0 and frame_err=0.
REQ-032 A reset asserted mid-frame SHALL abort the frame with no write; after release, the block SHALL wait for a fresh CS fall.

Structure
REQ-033 Package spi_regif_pkg SHALL hold CMD_WIDTH, ADDR_WIDTH, DATA_WIDTH, FRAME_LEN = 16, the WRITE = 0 / READ = 1 encodings and the FSM state enum.
REQ-034 Sub-module spi_sync_edge SHALL implement the 2-FF synchronizer plus rise/fall detect, instantiated once per SPI input.

Verification
REQ-035 Scenario: after reset, read frames to addresses 0 and 15 -> MISO returns 0x000 for both.
REQ-036 Scenario: write frame 0x05A5 sets addr 0 to 0x5A5, then read frame 0x8000 -> MISO returns 0x5A5, reg_wr pulsed once with waddr 0, and cfg_rdata(0) = 0x5A5.
REQ-037 Scenario: write to addr 3 with CS raised after 10 bits -> no reg_wr, one frame_err pulse, and reg 3 still reads 0.
REQ-038 Scenario: 20-bit write frame to addr 7 with data 0x7FF followed by 4 extra bits -> exactly one write, and reg 7 = 0x7FF.
REQ-039 Scenario: sys_rst pulsed after the 8th bit of a write to addr 2 -> no write; the next full frame to addr 2 with data 0x123 succeeds.
REQ-040 Scenario: consecutive write and read frames to addr 9 with data 0x2AA, separated by tHI_SCS = 400 ns -> the read returns 0x2AA.

Source files
------------

// File: rtl/spi_regif_pkg.sv
// rtl/spi_regif_pkg.sv - shared widths, command encodings and FSM states for the SPI register slave
package spi_regif_pkg;

    localparam int CMD_WIDTH  = 5;
    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 11;
    localparam int FRAME_LEN  = CMD_WIDTH + DATA_WIDTH;

    // Leading frame bit: direction of the transfer
    localparam logic WRITE = 1'b0;
    localparam logic READ  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_DONE
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - two-flop synchronizer with rise/fall detect for one SPI pin
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic sync_d;

    // Two-stage synchronizer plus one delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= RST_VAL;
            sync   <= RST_VAL;
            sync_d <= RST_VAL;
        end else begin
            meta   <= din;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign q    = sync;
    assign rise = sync & ~sync_d;
    assign fall = ~sync & sync_d;

endmodule

// File: rtl/spi_slave_regif.sv
// rtl/spi_slave_regif.sv - SPI mode-0 slave giving read/write access to a small register file
module spi_slave_regif
    import spi_regif_pkg::*;
#(
    parameter int CMD_WIDTH  = spi_regif_pkg::CMD_WIDTH,
    parameter int ADDR_WIDTH = spi_regif_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = spi_regif_pkg::DATA_WIDTH
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  spi_cs_n,
    input  logic                  spi_sclk,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    output logic                  reg_wr,
    output logic [ADDR_WIDTH-1:0] reg_waddr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    input  logic [ADDR_WIDTH-1:0] cfg_raddr,
    output logic [DATA_WIDTH-1:0] cfg_rdata,
    output logic                  frame_err
);

    localparam int FRAME_BITS = CMD_WIDTH + DATA_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam int NREGS      = 1 << ADDR_WIDTH;

    localparam logic [CNT_W-1:0] CNT_CMD_LAST   = CNT_W'(CMD_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FRAME_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL       = CNT_W'(FRAME_BITS);

    logic cs_s, cs_rise, cs_fall_raw, cs_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_sync;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-2:0] rx_shift;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] regs [NREGS];
    logic                  load_pend;
    logic                  is_read;
    logic                  miso_q;
    logic [1:0]            sync_vld;
    logic                  armed;

    logic in_frame;
    logic shift_en;
    logic cmd_done;
    logic frame_done;
    logic abort;
    logic commit_wr;

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .din  (spi_cs_n),
        .q    (cs_s),
        .rise (cs_rise),
        .fall (cs_fall_raw)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .din  (spi_sclk),
        .q    (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .din  (spi_mosi),
        .q    (mosi_s),
        .rise (mosi_rise),
        .fall (mosi_fall)
    );

    assign unused_sync = &{1'b0, sclk_s, mosi_rise, mosi_fall};

    // Arm only after a genuine high CS sample so a CS held low through reset cannot start a frame
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_vld <= '0;
            armed    <= 1'b0;
        end else begin
            sync_vld <= {sync_vld[0], 1'b1};
            if (sync_vld[1] && cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign cs_fall     = cs_fall_raw & armed;
    assign spi_miso_oe = ~cs_s;

    // FSM state register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: CS rise always returns to idle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cs_fall) state_nxt = ST_CMD;
            ST_CMD: begin
                if (cs_rise)       state_nxt = ST_IDLE;
                else if (cmd_done) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (cs_rise)         state_nxt = ST_IDLE;
                else if (frame_done) state_nxt = ST_DONE;
            end
            ST_DONE: if (cs_rise) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: per-cycle strobes steering the datapath
    always_comb begin
        in_frame   = (state == ST_CMD) || (state == ST_DATA);
        shift_en   = in_frame && sclk_rise && !cs_rise;
        cmd_done   = (state == ST_CMD) && shift_en && (bit_cnt == CNT_CMD_LAST);
        frame_done = (state == ST_DATA) && shift_en && (bit_cnt == CNT_FRAME_LAST);
        abort      = in_frame && cs_rise && (bit_cnt != '0);
        commit_wr  = frame_done && (rx_shift[FRAME_BITS-2] == WRITE);
    end

    // Receive path: MOSI sampled on each SCLK rise, counter saturates at a full frame
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
        end else if (cs_fall) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
        end else if (shift_en) begin
            rx_shift <= {rx_shift[FRAME_BITS-3:0], mosi_s};
            if (bit_cnt != CNT_FULL) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // Transmit path: load read data after the command, shift out on SCLK falls during DATA only
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            load_pend <= 1'b0;
            is_read   <= 1'b0;
            tx_shift  <= '0;
            miso_q    <= 1'b0;
        end else if (cs_fall) begin
            load_pend <= 1'b0;
            is_read   <= 1'b0;
            tx_shift  <= '0;
            miso_q    <= 1'b0;
        end else begin
            load_pend <= cmd_done;
            if (load_pend) begin
                is_read <= (rx_shift[CMD_WIDTH-1] == READ);
                if (rx_shift[CMD_WIDTH-1] == READ) begin
                    tx_shift <= regs[rx_shift[ADDR_WIDTH-1:0]];
                end
            end
            if ((state != ST_DATA) || !is_read) begin
                miso_q <= 1'b0;
            end else if (sclk_fall) begin
                miso_q   <= tx_shift[DATA_WIDTH-1];
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    assign spi_miso = miso_q;

    // Write commit strobe and short-frame error pulse
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            reg_wr    <= 1'b0;
            reg_waddr <= '0;
            reg_wdata <= '0;
            frame_err <= 1'b0;
        end else begin
            reg_wr    <= commit_wr;
            frame_err <= abort;
            if (commit_wr) begin
                reg_waddr <= rx_shift[FRAME_BITS-3 -: ADDR_WIDTH];
                reg_wdata <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
            end
        end
    end

    // Register file updates in the strobe cycle, so a same-cycle core read still sees the old value
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_wr) begin
            regs[reg_waddr] <= reg_wdata;
        end
    end

    assign cfg_rdata = regs[cfg_raddr];

endmodule

// File: tb/tb_spi_slave_regif.sv
// tb/tb_spi_slave_regif.sv - directed self-checking bench for spi_slave_regif
module tb_spi_slave_regif;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        spi_cs_n;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic        reg_wr;
    logic [3:0]  reg_waddr;
    logic [10:0] reg_wdata;
    logic [3:0]  cfg_raddr;
    logic [10:0] cfg_rdata;
    logic        frame_err;

    int vectors     = 0;
    int miscompares = 0;

    int          wr_count   = 0;
    int          ferr_count = 0;
    logic [3:0]  last_waddr = '0;
    logic [10:0] last_wdata = '0;
    logic [10:0] rd_during  = '0;
    logic [10:0] rd_after   = '0;
    logic        pend       = 1'b0;

    always #5 sys_clk = ~sys_clk;

    spi_slave_regif dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .spi_cs_n    (spi_cs_n),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .reg_wr      (reg_wr),
        .reg_waddr   (reg_waddr),
        .reg_wdata   (reg_wdata),
        .cfg_raddr   (cfg_raddr),
        .cfg_rdata   (cfg_rdata),
        .frame_err   (frame_err)
    );

    always @(negedge sys_clk) begin
        if (reg_wr) begin
            wr_count   <= wr_count + 1;
            last_waddr <= reg_waddr;
            last_wdata <= reg_wdata;
            rd_during  <= cfg_rdata;
            pend       <= 1'b1;
        end else if (pend) begin
            rd_after <= cfg_rdata;
            pend     <= 1'b0;
        end
        if (frame_err) ferr_count <= ferr_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic m);
        spi_mosi = b;
        #40 spi_sclk = 1'b1;
        m = spi_miso;
        #40 spi_sclk = 1'b0;
    endtask

    task automatic spi_frame(input logic [31:0] word, input int nbits,
                             output logic [31:0] rx, output logic oe_mid);
        logic b;
        rx = '0;
        spi_cs_n = 1'b0;
        #40;
        oe_mid = spi_miso_oe;
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_bit(word[i], b);
            rx = {rx[30:0], b};
        end
        #40 spi_cs_n = 1'b1;
        #400;
    endtask

    initial begin
        logic [31:0] rx;
        logic        oe;
        logic        b;
        int          w0;
        int          e0;

        sys_rst   = 1'b1;
        spi_cs_n  = 1'b1;
        spi_sclk  = 1'b0;
        spi_mosi  = 1'b0;
        cfg_raddr = 4'd0;
        #40;
        chk("rst_miso",  32'(spi_miso), 0);
        chk("rst_oe",    32'(spi_miso_oe), 0);
        chk("rst_wr",    32'(reg_wr), 0);
        chk("rst_waddr", 32'(reg_waddr), 0);
        chk("rst_wdata", 32'(reg_wdata), 0);
        chk("rst_ferr",  32'(frame_err), 0);
        chk("rst_rdata", 32'(cfg_rdata), 0);
        sys_rst = 1'b0;
        #100;
        chk("idle_oe", 32'(spi_miso_oe), 0);

        // Reads of a freshly reset register file
        spi_frame(32'h8000, 16, rx, oe);
        chk("rd0_miso", rx, 32'h0000);
        chk("rd0_oe",   32'(oe), 1);
        spi_frame(32'hF800, 16, rx, oe);
        chk("rd15_miso", rx, 32'h0000);

        // Write 0x5A5 to addr 0, then read it back
        cfg_raddr = 4'd0;
        w0 = wr_count;
        spi_frame(32'h05A5, 16, rx, oe);
        chk("wr0_miso_zero", rx, 0);
        chk("wr0_count",     32'(wr_count - w0), 1);
        chk("wr0_waddr",     32'(last_waddr), 0);
        chk("wr0_wdata",     32'(last_wdata), 32'h5A5);
        chk("wr0_old_rd",    32'(rd_during), 0);
        chk("wr0_new_rd",    32'(rd_after), 32'h5A5);
        chk("wr0_cfg",       32'(cfg_rdata), 32'h5A5);
        chk("post_miso",     32'(spi_miso), 0);
        chk("post_oe",       32'(spi_miso_oe), 0);
        spi_frame(32'h8000, 16, rx, oe);
        chk("rd0b_miso",  rx, 32'h05A5);
        chk("rd0b_count", 32'(wr_count - w0), 1);

        // Short write to addr 3 aborted after 10 bits
        cfg_raddr = 4'd3;
        w0 = wr_count;
        e0 = ferr_count;
        spi_frame(32'h1FFF >> 6, 10, rx, oe);
        chk("short_count", 32'(wr_count - w0), 0);
        chk("short_ferr",  32'(ferr_count - e0), 1);
        chk("short_cfg",   32'(cfg_rdata), 0);

        // Chip select toggle with no clocks is not an error
        e0 = ferr_count;
        spi_frame(32'h0, 0, rx, oe);
        chk("empty_ferr", 32'(ferr_count - e0), 0);

        // 20-bit write to addr 7: extra bits ignored
        cfg_raddr = 4'd7;
        w0 = wr_count;
        e0 = ferr_count;
        spi_frame(32'h3FFFA, 20, rx, oe);
        chk("long_count", 32'(wr_count - w0), 1);
        chk("long_waddr", 32'(last_waddr), 7);
        chk("long_wdata", 32'(last_wdata), 32'h7FF);
        chk("long_cfg",   32'(cfg_rdata), 32'h7FF);
        chk("long_ferr",  32'(ferr_count - e0), 0);
        spi_frame(32'hB800F, 20, rx, oe);
        chk("long_rd_miso", rx, 32'h7FF0);

        // Reset in the middle of a write to addr 2
        w0 = wr_count;
        e0 = ferr_count;
        spi_cs_n = 1'b0;
        #40;
        for (int i = 15; i >= 8; i--) spi_bit(1'((32'h1123 >> i) & 1), b);
        sys_rst = 1'b1;
        #30 sys_rst = 1'b0;
        #40;
        chk("mid_rst_oe", 32'(spi_miso_oe), 1);
        for (int i = 7; i >= 0; i--) spi_bit(1'((32'h1123 >> i) & 1), b);
        #40 spi_cs_n = 1'b1;
        #400;
        chk("mid_rst_count", 32'(wr_count - w0), 0);
        chk("mid_rst_ferr",  32'(ferr_count - e0), 0);
        cfg_raddr = 4'd0;
        #10;
        chk("mid_rst_reg0", 32'(cfg_rdata), 0);
        cfg_raddr = 4'd2;
        #10;
        chk("mid_rst_reg2", 32'(cfg_rdata), 0);
        spi_frame(32'h1123, 16, rx, oe);
        chk("after_rst_count", 32'(wr_count - w0), 1);
        chk("after_rst_waddr", 32'(last_waddr), 2);
        chk("after_rst_cfg",   32'(cfg_rdata), 32'h123);

        // Back-to-back write then read of addr 9
        cfg_raddr = 4'd9;
        spi_frame(32'h4AAA, 16, rx, oe);
        spi_frame(32'hC800, 16, rx, oe);
        chk("b2b_rd_miso", rx, 32'h02AA);
        chk("b2b_cfg",     32'(cfg_rdata), 32'h2AA);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
